team_06_echo_delay_buffer: RTL

//  Delay-line storage stage beside team_06_echo_effect. Stores every processed sample
//  (save_audio) in a circular buffer held in external SRAM. Serves echo_effect's

---
 rtl/team_06_echo_delay_buffer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/team_06_echo_delay_buffer.sv
// team_06_echo_delay_buffer
//   Delay-line storage stage for the echo effect. Every processed sample is
//   written into a circular buffer held in external SRAM; search requests read
//   back the sample stored `offset` ticks ago. One memory port is shared by
//   write and read traffic, with writes taking priority.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   sample_tick/save_audio   store request + 8-bit sample
//   search/offset       fetch request + distance back (0 = newest sample)
//   past_output/search_enable   fetched sample + 1-cycle valid strobe
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack   SRAM handshake
//   overrun             sticky: a pending sample was lost or an access aborted
//   full                sticky: DEPTH samples have been stored
// Optional feature: define TEAM06_ECHO_DBUF_TIMEOUT_EN to abort an access that
//   sees no mem_ack within TIMEOUT cycles.
module team_06_echo_delay_buffer #(
  parameter int DEPTH   = 8192,
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [7:0]        save_audio,
  input  logic              search,
  input  logic [12:0]       offset,
  output logic [7:0]        past_output,
  output logic              search_enable,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              overrun,
  output logic              full
);

  localparam int FW    = ADDR_W + 1;
  localparam int CW    = 14;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               full_q, full_d;
  logic               wp_q, wp_d;
  logic [7:0]         wr_pend_q, wr_pend_d;
  logic               rp_q, rp_d;
  logic [12:0]        rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         past_q, past_d;
  logic               overrun_q, overrun_d;

  logic               launch_wr, launch_rd, rd_ok, tmo_hit;
  logic [ADDR_W-1:0]  rd_addr;

  // The pending slots are handed to the memory stage when an access launches,
  // so a strobe arriving during a stalled access queues behind it.
  assign launch_wr = (state_q == IDLE) && wp_q;
  assign launch_rd = (state_q == IDLE) && !wp_q && rp_q;
  assign rd_ok     = ({1'b0, rd_pend_q} < CW'(fill_q)) && ({1'b0, rd_pend_q} < CW'(DEPTH));
  // Offset truncation is harmless: the address is modulo DEPTH anyway.
  assign rd_addr   = wr_ptr_q - ADDR_W'(1) - rd_pend_q[ADDR_W-1:0];

`ifdef TEAM06_ECHO_DBUF_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = mem_req && !mem_ack && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_d = '0;
    if (mem_req && !mem_ack && !tmo_hit) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = TMO_W'(TIMEOUT);
  assign tmo_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (wp_q)      state_d = WRITE;
             else if (rp_q) state_d = rd_ok ? READ : DONE;
      WRITE: if (mem_ack || tmo_hit) state_d = IDLE;
      READ:  if (mem_ack || tmo_hit) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    search_enable = 1'b0;
    case (state_q)
      WRITE:   begin mem_req = 1'b1; mem_we = 1'b1; end
      READ:    mem_req = 1'b1;
      DONE:    search_enable = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign past_output = past_q;
  assign overrun     = overrun_q;
  assign full        = full_q;

  // Datapath
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    wp_d      = wp_q;
    wr_pend_d = wr_pend_q;
    rp_d      = rp_q;
    rd_pend_d = rd_pend_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    past_d    = past_q;
    overrun_d = overrun_q;

    if (launch_wr) begin
      wp_d    = 1'b0;
      addr_d  = wr_ptr_q;
      wdata_d = wr_pend_q;
    end else if (launch_rd) begin
      rp_d = 1'b0;
      if (rd_ok) addr_d = rd_addr;
      else       past_d = '0;         // nothing stored that far back: silence
    end

    case (state_q)
      WRITE: if (mem_ack) begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
             end else if (tmo_hit) begin
               overrun_d = 1'b1;
             end
      READ:  if (mem_ack) begin
               past_d = mem_rdata;
             end else if (tmo_hit) begin
               past_d    = '0;
               overrun_d = 1'b1;
             end
      default: ;
    endcase

    // New strobes win over the launch-time clears above.
    if (sample_tick) begin
      if (wp_q && !launch_wr) overrun_d = 1'b1;
      wp_d      = 1'b1;
      wr_pend_d = save_audio;
    end
    if (search) begin
      rp_d      = 1'b1;
      rd_pend_d = offset;
    end

    full_d = full_q | (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      wp_q      <= 1'b0;
      wr_pend_q <= '0;
      rp_q      <= 1'b0;
      rd_pend_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      past_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      wp_q      <= wp_d;
      wr_pend_q <= wr_pend_d;
      rp_q      <= rp_d;
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      past_q    <= past_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
